// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the gate self-test checker: FSM encoding and
// reference truth tables for two-input gates (bit i = y for vector i).
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int SETTLE_W = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/truth_table_checker_vec_sequencer.sv
// Walks every input vector once per run, holding each for SETTLE+1 cycles
// and flagging the cycle on which the gate output should be sampled.
module vec_sequencer
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            run,
  output logic [N_IN-1:0] stim,
  output logic            sample_en,
  output logic            last_vec
);

  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  logic [N_IN-1:0]     stim_r;
  logic [SETTLE_W-1:0] settle_r;

  // Vector counter and per-vector settle countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_r   <= {N_IN{1'b0}};
      settle_r <= {SETTLE_W{1'b0}};
    end else if (load) begin
      stim_r   <= {N_IN{1'b0}};
      settle_r <= SETTLE_V;
    end else if (run) begin
      if (settle_r != {SETTLE_W{1'b0}}) begin
        settle_r <= settle_r - SETTLE_W'(1'b1);
      end else if (stim_r == {N_IN{1'b1}}) begin
        // Final vector sampled: park at zero, never wrap into a second pass
        stim_r   <= {N_IN{1'b0}};
        settle_r <= {SETTLE_W{1'b0}};
      end else begin
        stim_r   <= stim_r + N_IN'(1'b1);
        settle_r <= SETTLE_V;
      end
    end else begin
      stim_r   <= {N_IN{1'b0}};
      settle_r <= {SETTLE_W{1'b0}};
    end
  end

  assign stim      = stim_r;
  assign sample_en = run && (settle_r == {SETTLE_W{1'b0}});
  assign last_vec  = (stim_r == {N_IN{1'b1}});

endmodule

// File: rtl/truth_table_checker.sv
// Built-in self-test around a combinational gate: applies all 2^N_IN vectors,
// compares each settled output against EXPECT and reports a registered verdict.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = TT_AND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_vec
);

  state_e          state_r, state_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic            pass_r, pass_nxt_s;
  logic [N_IN:0]   fail_count_r, fail_count_nxt_s;
  logic [N_IN-1:0] first_fail_vec_r, first_fail_vec_nxt_s;

  logic [N_IN-1:0] stim_s;
  logic            sample_en_s, last_vec_s;
  logic            load_s, run_s;
  logic            mismatch_s, fail_inc_s;
  logic [N_IN:0]   fail_sum_s;

  assign load_s = (state_r == ST_IDLE) && start;
  assign run_s  = (state_r == ST_RUN);

  vec_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_sequencer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .run       (run_s),
    .stim      (stim_s),
    .sample_en (sample_en_s),
    .last_vec  (last_vec_s)
  );

  // Case inequality so an X/Z gate output is scored as a mismatch
  assign mismatch_s = (dut_y !== EXPECT[stim_s]);
  assign fail_inc_s = sample_en_s && mismatch_s;
  assign fail_sum_s = fail_count_r + {{N_IN{1'b0}}, fail_inc_s};

  // Next-state and next-output logic for the IDLE/RUN/FIN sequencer
  always_comb begin
    state_nxt_s          = state_r;
    busy_nxt_s           = busy_r;
    done_nxt_s           = 1'b0;
    pass_nxt_s           = pass_r;
    fail_count_nxt_s     = fail_count_r;
    first_fail_vec_nxt_s = first_fail_vec_r;
    case (state_r)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s          = ST_RUN;
          busy_nxt_s           = 1'b1;
          pass_nxt_s           = 1'b0;
          fail_count_nxt_s     = {(N_IN+1){1'b0}};
          first_fail_vec_nxt_s = {N_IN{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy_nxt_s       = 1'b1;
        fail_count_nxt_s = fail_sum_s;
        if (fail_inc_s && (fail_count_r == {(N_IN+1){1'b0}})) begin
          first_fail_vec_nxt_s = stim_s;
        end else begin
          first_fail_vec_nxt_s = first_fail_vec_r;
        end
        // Verdict folds in the final sample taken on this same edge
        if (sample_en_s && last_vec_s) begin
          state_nxt_s = ST_FIN;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          pass_nxt_s  = (fail_sum_s == {(N_IN+1){1'b0}});
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      fail_count_r     <= {(N_IN+1){1'b0}};
      first_fail_vec_r <= {N_IN{1'b0}};
    end else begin
      state_r          <= state_nxt_s;
      busy_r           <= busy_nxt_s;
      done_r           <= done_nxt_s;
      pass_r           <= pass_nxt_s;
      fail_count_r     <= fail_count_nxt_s;
      first_fail_vec_r <= first_fail_vec_nxt_s;
    end
  end

  assign stim           = stim_s;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign fail_count     = fail_count_r;
  assign first_fail_vec = first_fail_vec_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker instances (SETTLE=1/AND and SETTLE=0/XOR)
// against a run-timeline model, directed scenarios plus randomized traffic.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start     [2];
  logic [1:0] stim_a    [2];
  logic       dut_y_a   [2];
  logic       busy_a    [2];
  logic       done_a    [2];
  logic       pass_a    [2];
  logic [2:0] fc_a      [2];
  logic [1:0] ffv_a     [2];
  logic [3:0] gate_tt   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // model state per instance: k = edges since accepted start, -1 when idle
  int k_m[2], stim_m[2], busy_m[2], done_m[2], pass_m[2], fc_m[2], ffv_m[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int         S_G = (g == 0) ? 1 : 0;
    localparam logic [3:0] E_G = (g == 0) ? 4'b1000 : 4'b0110;
    truth_table_checker #(.N_IN(2), .SETTLE(S_G), .EXPECT(E_G)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start[g]),
      .stim           (stim_a[g]),
      .dut_y          (dut_y_a[g]),
      .busy           (busy_a[g]),
      .done           (done_a[g]),
      .pass           (pass_a[g]),
      .fail_count     (fc_a[g]),
      .first_fail_vec (ffv_a[g])
    );
    assign dut_y_a[g] = gate_tt[g][stim_a[g]];
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, g, $time, act, exp);
    end
  endtask

  task automatic model_edge(input int g);
    int s, len, v;
    logic [3:0] e;
    s   = (g == 0) ? 1 : 0;
    e   = (g == 0) ? 4'b1000 : 4'b0110;
    len = 4 * (s + 1);
    if (!rst_n) begin
      k_m[g] = -1; stim_m[g] = 0; busy_m[g] = 0; done_m[g] = 0;
      pass_m[g] = 0; fc_m[g] = 0; ffv_m[g] = 0;
    end else if (k_m[g] < 0) begin
      done_m[g] = 0; busy_m[g] = 0; stim_m[g] = 0;
      if (start[g]) begin
        k_m[g] = 0; busy_m[g] = 1; fc_m[g] = 0; ffv_m[g] = 0; pass_m[g] = 0;
      end
    end else begin
      k_m[g]++;
      if (k_m[g] > len) begin
        k_m[g] = -1; done_m[g] = 0; busy_m[g] = 0; stim_m[g] = 0;
      end else begin
        if (k_m[g] % (s + 1) == 0) begin
          v = k_m[g] / (s + 1) - 1;
          if (gate_tt[g][v] !== e[v]) begin
            if (fc_m[g] == 0) ffv_m[g] = v;
            fc_m[g]++;
          end
        end
        if (k_m[g] == len) begin
          done_m[g] = 1; busy_m[g] = 0; stim_m[g] = 0; pass_m[g] = (fc_m[g] == 0) ? 1 : 0;
        end else begin
          stim_m[g] = k_m[g] / (s + 1);
        end
      end
    end
  endtask

  // one clock: advance model on the rising edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    for (int g = 0; g < 2; g++) model_edge(g);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("stim", g, 32'(stim_a[g]), 32'(stim_m[g]));
      chk("busy", g, 32'(busy_a[g]), 32'(busy_m[g]));
      chk("done", g, 32'(done_a[g]), 32'(done_m[g]));
      chk("pass", g, 32'(pass_a[g]), 32'(pass_m[g]));
      chk("fail_count", g, 32'(fc_a[g]), 32'(fc_m[g]));
      chk("first_fail_vec", g, 32'(ffv_a[g]), 32'(ffv_m[g]));
    end
  endtask

  // start pulse, optional mid-run re-pulse, bounded wait for done, literal results
  task automatic run_lit(input string nm, input int g, input logic [3:0] gtt, input int repulse,
                         input int exp_edge, input int exp_fc, input int exp_ffv, input int exp_pass);
    int e;
    gate_tt[g] = gtt;
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
    e = 0;
    while (done_a[g] !== 1'b1 && e < 60) begin
      start[g] = (repulse != 0 && e + 1 == repulse);
      step();
      start[g] = 1'b0;
      e++;
    end
    chk({nm, "_done_edge"}, g, 32'(e), 32'(exp_edge));
    chk({nm, "_fail_count"}, g, 32'(fc_a[g]), 32'(exp_fc));
    chk({nm, "_first_fail"}, g, 32'(ffv_a[g]), 32'(exp_ffv));
    chk({nm, "_pass"}, g, 32'(pass_a[g]), 32'(exp_pass));
    step();
    chk({nm, "_done_fall"}, g, 32'(done_a[g]), 32'd0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      k_m[g] = -1; stim_m[g] = 0; busy_m[g] = 0; done_m[g] = 0;
      pass_m[g] = 0; fc_m[g] = 0; ffv_m[g] = 0;
      start[g] = 1'b0; gate_tt[g] = 4'b1000;
    end
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_busy", 0, 32'(busy_a[0]), 32'd0);
    chk("reset_pass", 1, 32'(pass_a[1]), 32'd0);
    rst_n = 1'b1;
    step();

    run_lit("and_ok",      0, 4'b1000, 0, 8, 0, 0, 1);
    run_lit("or_vs_and",   0, 4'b1110, 0, 8, 2, 1, 0);
    run_lit("and_vs_xor",  1, 4'b1000, 0, 4, 3, 1, 0);
    run_lit("xor_ok_s0",   1, 4'b0110, 0, 4, 0, 0, 1);
    run_lit("repulse_ign", 0, 4'b1000, 3, 8, 0, 0, 1);

    // reset asserted during vector 10, then a fresh run
    gate_tt[0] = 4'b1000;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("midreset_busy", 0, 32'(busy_a[0]), 32'd0);
    chk("midreset_done", 0, 32'(done_a[0]), 32'd0);
    step();
    chk("midreset_stim", 0, 32'(stim_a[0]), 32'd0);
    rst_n = 1'b1;
    run_lit("after_reset", 0, 4'b1000, 0, 8, 0, 0, 1);

    // randomized traffic: random starts, gates, occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int g = 0; g < 2; g++) begin
        start[g] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 3))
            0:       gate_tt[g] = 4'b1000;
            1:       gate_tt[g] = 4'b1110;
            2:       gate_tt[g] = 4'b0110;
            default: gate_tt[g] = 4'($urandom);
          endcase
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Built-in self-test stage placed around an elementary gate (and_gate, or_gate, ...). It drives every input combination into the gate-under-test and samples the gate's output. Each sample is compared with a parameterised truth table. The block reports a pass/fail verdict, a mismatch count and the first failing vector. It replaces hand-written stimulus sequences with a reusable, synthesizable sequencer plus checker.

Parameters:
N_IN, 2, number of gate inputs; the block walks 2^N_IN vectors.
SETTLE, 1, extra cycles each vector is held before sampling (0..15).
EXPECT, 4'b1000, expected output truth table, width 2^N_IN; bit i is the expected y for vector i (AND by default).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request a run; accepted only in IDLE
stim  output  N_IN  vector to the gate-under-test (for N_IN=2: stim[1]->a, stim[0]->b)
dut_y  input  1  gate-under-test output y
busy  output  1  high while vectors are being applied
done  output  1  one-cycle pulse at end of run
pass  output  1  high when last run had zero mismatches
fail_count  output  N_IN+1  mismatches in last run (0..2^N_IN)
first_fail_vec  output  N_IN  first mismatching vector of last run; 0 if none

Behaviour:
- One clock; reset is synchronous and active-low; all state is updated on the rising edge of clk only.
- Reset values (rst_n=0 at an edge): state=IDLE, stim=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, settle_cnt=0.
- Reset mid-run aborts at the next edge. All outputs take their reset values and no done pulse is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - stim=0, busy=0. Results from the previous run are held.
  - start=1 at an edge: enter RUN; stim=0, settle_cnt=SETTLE, fail_count=0, first_fail_vec=0, pass=0, busy=1.
- RUN:
  - If settle_cnt!=0: decrement settle_cnt and hold stim.
  - If settle_cnt==0: sample dut_y and compare with EXPECT[stim]. In simulation, X/Z on dut_y counts as a mismatch.
  - On mismatch: fail_count+=1. If this is the first mismatch of the run, first_fail_vec=stim.
  - If stim==all-ones: go to FIN and drop busy. Otherwise stim+=1 and settle_cnt=SETTLE.
- FIN (exactly one cycle):
  - done=1, busy=0, stim=0.
  - pass is registered as (fail_count==0), including the final sample.
  - Next edge returns to IDLE; done falls.
- Timing:
  - Each vector is held SETTLE+1 cycles and sampled on its last cycle.
  - start accepted at edge E0 gives busy=1 on edges E0 .. E0+2^N_IN*(SETTLE+1)-1.
  - done=1 in the cycle after edge E0+2^N_IN*(SETTLE+1).
  - Defaults: start at edge 0 gives done high after edge 8.
- Arithmetic and boundaries:
  - stim increments without wrap; the all-ones vector ends the run.
  - fail_count is N_IN+1 bits wide and saturates naturally at 2^N_IN, with no overflow.
- start behaviour:
  - start during RUN or FIN is ignored. It is not queued.
  - start held high continuously re-triggers a new run on the edge after FIN returns to IDLE.
- The DUT is purely combinational. Within SETTLE budget, dut_y must reflect the current stim at the sampling edge; no pipelined-DUT compensation is provided.

Decomposition:
- Shared header gate_test_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module, vec_sequencer, owns the stim counter and settle_cnt. Its outputs are stim, sample_en and last_vec.
- The top-level keeps the FSM and the compare/score logic.

Test Plan:
- Defaults, real and_gate on stim/dut_y, start pulse at edge 0 -> stim walks 00,00,01,01,10,10,11,11; done after edge 8; pass=1, fail_count=0, first_fail_vec=00.
- EXPECT=TT_AND with dut_y driven by an OR gate -> mismatches at vectors 01 and 10; pass=0, fail_count=2, first_fail_vec=01.
- EXPECT=TT_XOR with and_gate -> mismatches at 01, 10, 11; fail_count=3, first_fail_vec=01, pass=0.
- SETTLE=0 with and_gate -> each vector is held one cycle; busy high for 4 cycles; done after edge 4; pass=1.
- start re-pulsed at edge 3 (mid-run) -> ignored; run timing and results match the first scenario.
- rst_n=0 at edge 5 (during vector 10), released at edge 6, start at edge 7 -> outputs at reset values on edges 5..6 with no done pulse; new run completes with done after edge 15 and pass=1.
